// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmitter with an input FIFO and configurable framing
// Queued words are framed as start/data/parity/stop and sent back-to-back with no idle gap.
module uart_tx_frame #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset,
    input  logic                        i_Tx_DV,
    input  logic [DATA_BITS-1:0]        i_Tx_Byte,
    output logic                        o_Tx_Ready,
    output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count,
    output logic                        o_Tx_Active,
    output logic                        o_Tx_Serial,
    output logic                        o_Tx_Done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int NW = PW + 1;

    localparam logic [CW-1:0] CLK_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST  = (STOP_BITS == 2);
    localparam logic [NW-1:0] FULL_COUNT = NW'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]        count_q, count_d;
    logic                 push;
    logic                 pop;
    logic                 have_word;
    logic [DATA_BITS-1:0] head;

    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 serial_q, serial_d;
    logic                 active_q, active_d;
    logic                 clk_last;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
        return (PARITY == 1) ? ~(^w) : (^w);
    endfunction

    assign o_Tx_Ready   = (count_q != FULL_COUNT);
    assign o_Fifo_Count = count_q;
    assign o_Tx_Active  = active_q;
    assign o_Tx_Serial  = serial_q;
    assign push         = i_Tx_DV & o_Tx_Ready;
    assign have_word    = (count_q != '0);
    assign head         = mem_q[rd_ptr_q];
    assign clk_last     = (clk_cnt_q == CLK_LAST);

    // Done is decoded from registered state so it vanishes with the async reset.
    assign o_Tx_Done = (state_q == S_STOP) && clk_last && (stop_cnt_q == STOP_LAST);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + NW'(1);
        end else if (!push && pop) begin
            count_d = count_q - NW'(1);
        end
    end

    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_Tx_Byte;
        end
    end

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q + CW'(1);
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        serial_d   = serial_q;
        active_d   = active_q;
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                serial_d  = 1'b1;
                active_d  = 1'b0;
                pop       = have_word;
            end
            S_START: begin
                if (clk_last) begin
                    state_d   = S_DATA;
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    serial_d  = shift_q[0];
                end
            end
            S_DATA: begin
                if (clk_last) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == IDX_LAST) begin
                        bit_idx_d = '0;
                        if (PARITY != 0) begin
                            state_d  = S_PARITY;
                            serial_d = parity_q;
                        end else begin
                            state_d  = S_STOP;
                            serial_d = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IW'(1);
                        shift_d   = shift_q >> 1;
                        serial_d  = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (clk_last) begin
                    state_d   = S_STOP;
                    clk_cnt_d = '0;
                    serial_d  = 1'b1;
                end
            end
            S_STOP: begin
                serial_d = 1'b1;
                if (clk_last) begin
                    clk_cnt_d = '0;
                    if (stop_cnt_q == STOP_LAST) begin
                        stop_cnt_d = 1'b0;
                        if (have_word) begin
                            pop = 1'b1;
                        end else begin
                            state_d  = S_IDLE;
                            active_d = 1'b0;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                clk_cnt_d  = '0;
                bit_idx_d  = '0;
                stop_cnt_d = 1'b0;
                serial_d   = 1'b1;
                active_d   = 1'b0;
            end
        endcase

        // Loading a word is shared by the idle start and the back-to-back restart from STOP.
        if (pop) begin
            state_d    = S_START;
            clk_cnt_d  = '0;
            bit_idx_d  = '0;
            stop_cnt_d = 1'b0;
            shift_d    = head;
            parity_d   = parity_of(head);
            serial_d   = 1'b0;
            active_d   = 1'b1;
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            serial_q   <= 1'b1;
            active_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            serial_q   <= serial_d;
            active_q   <= active_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - self-checking bench for uart_tx_frame over four framing configurations
module tb_uart_tx_frame;
    localparam int N     = 4;
    localparam int DEPTH = 4;

    typedef struct {
        int          dut;
        logic [8:0]  word;
        int          nbits;
        logic [15:0] bits;
    } frame_vec_t;

    logic       clk;
    logic       rst;
    logic       dv      [N];
    logic [8:0] tx_byte [N];
    logic       ready   [N];
    logic [2:0] cnt     [N];
    logic       active  [N];
    logic       serial  [N];
    logic       done    [N];

    logic [8:0] mq    [N][$];
    logic [8:0] fw    [N];
    int         fs    [N];
    int         nfree [N];
    int         t;
    int         vec;
    int         bad;

    frame_vec_t tbl [6];
    frame_vec_t v3c;

    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8n1 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[0]), .i_Tx_Byte(tx_byte[0][7:0]),
        .o_Tx_Ready(ready[0]), .o_Fifo_Count(cnt[0]), .o_Tx_Active(active[0]),
        .o_Tx_Serial(serial[0]), .o_Tx_Done(done[0]));

    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_7e2 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[1]), .i_Tx_Byte(tx_byte[1][6:0]),
        .o_Tx_Ready(ready[1]), .o_Fifo_Count(cnt[1]), .o_Tx_Active(active[1]),
        .o_Tx_Serial(serial[1]), .o_Tx_Done(done[1]));

    uart_tx_frame #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_7o2 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[2]), .i_Tx_Byte(tx_byte[2][6:0]),
        .o_Tx_Ready(ready[2]), .o_Fifo_Count(cnt[2]), .o_Tx_Active(active[2]),
        .o_Tx_Serial(serial[2]), .o_Tx_Done(done[2]));

    uart_tx_frame #(.CLKS_PER_BIT(868), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_slow (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(dv[3]), .i_Tx_Byte(tx_byte[3][7:0]),
        .o_Tx_Ready(ready[3]), .o_Fifo_Count(cnt[3]), .o_Tx_Active(active[3]),
        .o_Tx_Serial(serial[3]), .o_Tx_Done(done[3]));

    always #5 clk = ~clk;

    function automatic int cpb_of(int k);
        return (k == 3) ? 868 : 4;
    endfunction
    function automatic int db_of(int k);
        return (k == 1 || k == 2) ? 7 : 8;
    endfunction
    function automatic int par_of(int k);
        return (k == 1) ? 2 : ((k == 2) ? 1 : 0);
    endfunction
    function automatic int stop_of(int k);
        return (k == 1 || k == 2) ? 2 : 1;
    endfunction
    function automatic int flen(int k);
        return (1 + db_of(k) + ((par_of(k) != 0) ? 1 : 0) + stop_of(k)) * cpb_of(k);
    endfunction
    function automatic logic [8:0] mask_of(int k, logic [8:0] w);
        return w & 9'((1 << db_of(k)) - 1);
    endfunction

    // Line value during bit period p of a frame carrying w.
    function automatic logic frame_bit(int k, logic [8:0] w, int p);
        int         ones;
        logic [8:0] sh;
        ones = $countones(w);
        if (p == 0) return 1'b0;
        if (p <= db_of(k)) begin
            sh = w >> (p - 1);
            return sh[0];
        end
        if (par_of(k) != 0 && p == db_of(k) + 1) return (par_of(k) == 2) ? ones[0] : ~ones[0];
        return 1'b1;
    endfunction

    function automatic logic [6:0] exp_vec(int k);
        int   d;
        logic in_frame;
        logic line;
        d        = t - fs[k];
        in_frame = (d >= 0) && (d < flen(k));
        line     = in_frame ? frame_bit(k, fw[k], d / cpb_of(k)) : 1'b1;
        return {(mq[k].size() < DEPTH), 3'(mq[k].size()), in_frame, line,
                in_frame && (d == flen(k) - 1)};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            mq[k].delete();
            fw[k]    = '0;
            fs[k]    = -1000000;
            nfree[k] = 0;
        end
    endtask

    // One rising edge: a frame starts whenever a word waits and the line is free.
    task automatic model_edge();
        t++;
        for (int k = 0; k < N; k++) begin
            int   cb;
            logic popk;
            logic acc;
            cb   = mq[k].size();
            popk = (cb > 0) && (t >= nfree[k]);
            acc  = dv[k] && (cb < DEPTH);
            if (popk) begin
                fw[k]    = mq[k].pop_front();
                fs[k]    = t;
                nfree[k] = t + flen(k);
            end
            if (acc) mq[k].push_back(mask_of(k, tx_byte[k]));
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < N; k++) begin
            logic [6:0] got;
            logic [6:0] want;
            got  = {ready[k], cnt[k], active[k], serial[k], done[k]};
            want = exp_vec(k);
            vec++;
            if (got !== want) begin
                bad++;
                $display("FAIL outputs dut%0d edge %0d: got %b want %b (ready,count,active,serial,done)",
                         k, t, got, want);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic drain();
        int n;
        logic busy;
        n    = 0;
        busy = 1'b1;
        while (busy && n < 20000) begin
            busy = 1'b0;
            for (int k = 0; k < N; k++) if (active[k] !== 1'b0 || cnt[k] !== 3'd0) busy = 1'b1;
            if (busy) begin
                cycle();
                n++;
            end
        end
        vec++;
        if (busy) begin
            bad++;
            $display("FAIL drain: still busy after %0d cycles, want idle", n);
        end
    endtask

    task automatic run_frame(input frame_vec_t v);
        int   c;
        int   done_n;
        int   done_at;
        logic ok;
        logic seen;
        c       = cpb_of(v.dut);
        done_n  = 0;
        done_at = -1;
        drain();
        dv[v.dut]      = 1'b1;
        tx_byte[v.dut] = v.word;
        cycle();
        dv[v.dut] = 1'b0;
        for (int b = 0; b < v.nbits; b++) begin
            ok   = 1'b1;
            seen = v.bits[b[3:0]];
            for (int i = 0; i < c; i++) begin
                cycle();
                if (serial[v.dut] !== v.bits[b[3:0]]) begin
                    ok   = 1'b0;
                    seen = serial[v.dut];
                end
                if (done[v.dut] === 1'b1) begin
                    done_n++;
                    done_at = b * c + i;
                end
            end
            vec++;
            if (!ok) begin
                bad++;
                $display("FAIL frame dut%0d word %h bit %0d: line got %b want %b for %0d cycles",
                         v.dut, v.word, b, seen, v.bits[b[3:0]], c);
            end
        end
        vec++;
        if (done_n != 1 || done_at != v.nbits * c - 1) begin
            bad++;
            $display("FAIL done dut%0d word %h: got %0d pulses at %0d, want 1 at %0d",
                     v.dut, v.word, done_n, done_at, v.nbits * c - 1);
        end
    endtask

    initial begin
        int act_n;
        int act_first;
        int act_last;
        int done_n;
        int s;

        clk = 1'b0;
        rst = 1'b1;
        t   = 0;
        vec = 0;
        bad = 0;
        for (int k = 0; k < N; k++) begin
            dv[k]      = 1'b0;
            tx_byte[k] = '0;
        end
        model_reset();

        tbl[0] = '{0, 9'h0A5, 10, 16'h034A};
        tbl[1] = '{1, 9'h055, 11, 16'h06AA};
        tbl[2] = '{2, 9'h055, 11, 16'h07AA};
        tbl[3] = '{1, 9'h07F, 11, 16'h07FE};
        tbl[4] = '{2, 9'h000, 11, 16'h0700};
        tbl[5] = '{3, 9'h0FF, 10, 16'h03FE};
        v3c    = '{0, 9'h03C, 10, 16'h0278};

        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_frame(tbl[i]);

        // Fill: five words fit (one leaves at once), the sixth meets a full FIFO.
        drain();
        act_n     = 0;
        act_first = -1;
        act_last  = -1;
        done_n    = 0;
        s         = 0;
        for (int i = 0; i < 266; i++) begin
            dv[0]      = (i < 6);
            tx_byte[0] = 9'(8'h10 + i);
            cycle();
            if (i == 5) begin
                vec++;
                if (cnt[0] !== 3'd4 || ready[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL fill: count/ready got %0d/%b want 4/0", cnt[0], ready[0]);
                end
            end
            if (active[0] === 1'b1) begin
                act_n++;
                if (act_first < 0) act_first = s;
                act_last = s;
            end
            if (done[0] === 1'b1) done_n++;
            s++;
        end
        dv[0] = 1'b0;
        vec++;
        if (act_n != 200 || act_last - act_first + 1 != 200 || done_n != 5 || cnt[0] !== 3'd0) begin
            bad++;
            $display("FAIL back-to-back: active %0d span %0d done %0d count %0d, want 200 200 5 0",
                     act_n, act_last - act_first + 1, done_n, cnt[0]);
        end

        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 3; k++) begin
                dv[k]      = ($urandom_range(0, 2) == 0);
                tx_byte[k] = 9'($urandom);
            end
            cycle();
        end
        for (int i = 0; i < 160; i++) begin
            dv[0]      = 1'b1;
            tx_byte[0] = 9'(i * 37);
            dv[1]      = 1'b1;
            tx_byte[1] = 9'($urandom);
            cycle();
        end
        for (int k = 0; k < N; k++) dv[k] = 1'b0;
        drain();

        // Reset in the middle of a data bit, away from any clock edge.
        dv[0]      = 1'b1;
        tx_byte[0] = 9'h0A5;
        dv[3]      = 1'b1;
        tx_byte[3] = 9'h0FF;
        cycle();
        dv[0] = 1'b0;
        dv[3] = 1'b0;
        repeat (14) cycle();
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < N; k++) begin
            vec++;
            if ({ready[k], cnt[k], active[k], serial[k], done[k]} !== 7'b1_000_0_1_0) begin
                bad++;
                $display("FAIL async reset dut%0d: got %b want 1000010 (ready,count,active,serial,done)",
                         k, {ready[k], cnt[k], active[k], serial[k], done[k]});
            end
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all();
        run_frame(v3c);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter with an input FIFO and configurable framing (data width, parity, stop bits). It replaces the fixed 8N1 transmitter in the serial output path. Bytes queued by the core are sent back-to-back without idle gaps. All state lives in one clock domain, with an asynchronous reset.

## Interface
- CLKS_PER_BIT, 868: clock cycles per bit; must be ≥ 2. The bit counter is $clog2(CLKS_PER_BIT) wide.
- DATA_BITS, 8: data bits per frame, 5..9, sent LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: number of FIFO entries; a power of two, ≥ 2.

Ports:
- i_Clock  in  1  sole clock, rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Tx_DV  in  1  write strobe; accepted when o_Tx_Ready = 1.
- i_Tx_Byte  in  DATA_BITS  data word to queue.
- o_Tx_Ready  out  1  FIFO not full; combinational from the registered count.
- o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  number of queued words.
- o_Tx_Active  out  1  high while a frame is on the line.
- o_Tx_Serial  out  1  serial line, registered; idles high.
- o_Tx_Done  out  1  single-cycle pulse at the end of each frame.

## Operation
- Reset values: o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Fifo_Count=0, o_Tx_Ready=1, FSM=IDLE.
- Push: on a rising edge where i_Tx_DV & o_Tx_Ready, i_Tx_Byte is written at the write pointer.
  - A push while full is silently dropped; the count is unchanged.
- Pop: performed by the FSM when a frame is loaded.
  - Simultaneous push and pop leaves the count unchanged and both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP, with these transitions.
  - IDLE: line is 1. If count > 0: pop into the shift register, compute parity, go to START, set Active=1.
  - START: line is 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: line is data[index] for CLKS_PER_BIT cycles per bit. After index DATA_BITS-1, go to PARITY (PARITY≠0) or to STOP.
  - PARITY: line is the parity bit for CLKS_PER_BIT cycles.
    - Odd: the number of ones across data plus parity is odd.
    - Even: that count is even.
  - STOP: line is 1 for STOP_BITS×CLKS_PER_BIT cycles. At the last cycle, o_Tx_Done is high for exactly one cycle.
    - If count > 0 at that edge: pop and go straight to START (Active stays 1).
    - Otherwise: go to IDLE and set Active=0.
- Illegal FSM encodings go to IDLE with the line at 1.
- The bit counter and the stop-bit counter reset to 0 on every state change.

## Timing
- Push into an empty FIFO with the FSM in IDLE:
  - The push edge is E0; count=1 after E0.
  - The FSM pops at E1. o_Tx_Serial falls and o_Tx_Active rises after E1.
  - count returns to 0 after E1. First-push latency to the start bit is 1 cycle.
- Frame length: F = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles, measured from the falling start edge to the next start edge or to the return to IDLE.
- Back-to-back frames have zero idle cycles between the last stop bit and the next start bit.
- o_Tx_Done is high in the final cycle of the stop period and low the following cycle. This holds even when the next frame starts.
- o_Tx_Ready drops in the cycle after the push that fills the FIFO. It rises in the cycle after the pop that frees an entry.
- Reset asserted mid-frame: all outputs take their reset values immediately, without waiting for a clock edge.
  - The line returns to 1.
  - The FIFO is emptied and the partial frame is lost.
- Deassertion of reset is synchronised externally. The first edge after deassertion may accept a push.

## Test plan
- Single 8N1 frame (CLKS_PER_BIT=4, defaults otherwise): push 0xA5 -> line 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles. Done pulses once, 40 cycles after the start edge.
- Parity and stop modes:
  - DATA_BITS=7, PARITY=2, STOP_BITS=2, push 0x55 -> parity bit 0, frame 11×CLKS_PER_BIT cycles.
  - Same setup with PARITY=1 -> parity bit 1.
- FIFO fill and back-to-back (FIFO_DEPTH=4):
  - Push 5 words on consecutive cycles -> Ready low once count=4 and the 5th is dropped only if count=4 at its edge.
  - Frames are transmitted contiguously with no idle cycles, Done pulses once per frame, and count ends at 0.
- Push while full with a simultaneous pop: the word is accepted only if Ready was high that cycle; the count stays consistent and the pointer wrap is verified over 10 words.
- Reset mid-DATA:
  - Assert i_Reset asynchronously -> Serial=1, Active=0, Count=0 within the same cycle.
  - After release, push 0x3C -> a correct frame is sent.
- CLKS_PER_BIT=868, push 0xFF -> each bit lasts exactly 868 cycles; this checks counter width.
